// File: rtl/lcd_sequencer.sv
// lcd_sequencer: owns a 4-bit HD44780-style bus. It runs the power-on init list,
// then turns accepted bytes into two timed nibble strobes and an execution wait.
module lcd_sequencer #(
  parameter int POWERUP_CYCLES    = 40,
  parameter int EN_HIGH_CYCLES    = 1,
  parameter int CMD_WAIT_CYCLES   = 2,
  parameter int CLEAR_WAIT_CYCLES = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [3:0] lcd_data
);

  localparam logic [2:0] S_PWR   = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EN    = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_IDLE  = 3'd5;

  localparam int CW = 16;
  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT_CYCLES - 1);

  localparam logic [3:0] STEP_LAST_INIT = 4'd7;
  localparam logic [3:0] STEP_USER      = 4'd8;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    step_q, step_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d;
  logic          lo_q, lo_d;
  logic          single_q, single_d;
  logic          long_q, long_d;
  logic          init_done_q, init_done_d;

  logic [3:0]    init_idx;
  logic [8:0]    init_sel;
  logic          init_long;

  // Init list entries are {single-nibble flag, byte}; single nibbles ride in the high half.
  function automatic logic [8:0] init_entry(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return {1'b1, 8'h30};
      4'd3:             return {1'b1, 8'h20};
      4'd4:             return {1'b0, 8'h28};
      4'd5:             return {1'b0, 8'h0C};
      4'd6:             return {1'b0, 8'h06};
      default:          return {1'b0, 8'h01};
    endcase
  endfunction

  function automatic logic needs_long(input logic rs, input logic [7:0] b);
    return !rs && (b == 8'h01 || b == 8'h02);
  endfunction

  assign init_idx  = (state_q == S_PWR) ? 4'd0 : step_q + 4'd1;
  assign init_sel  = init_entry(init_idx);
  // Only the very first wake-up nibble needs the long settle time.
  assign init_long = init_sel[8] ? (init_idx == 4'd0) : needs_long(1'b0, init_sel[7:0]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    lo_d        = lo_q;
    single_d    = single_q;
    long_d      = long_q;
    init_done_d = init_done_q;

    case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d    = '0;
          step_d   = 4'd0;
          byte_d   = init_sel[7:0];
          single_d = init_sel[8];
          rs_d     = 1'b0;
          lo_d     = 1'b0;
          long_d   = init_long;
          state_d  = S_SETUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_EN;
      end
      S_EN: begin
        if (cnt_q == EN_LAST) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (!single_q && !lo_q) begin
          lo_d    = 1'b1;
          state_d = S_SETUP;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == (long_q ? CLR_LAST : CMD_LAST)) begin
          cnt_d = '0;
          if (step_q < STEP_LAST_INIT) begin
            step_d   = step_q + 4'd1;
            byte_d   = init_sel[7:0];
            single_d = init_sel[8];
            rs_d     = 1'b0;
            lo_d     = 1'b0;
            long_d   = init_long;
            state_d  = S_SETUP;
          end else begin
            step_d      = STEP_USER;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          byte_d   = req_data;
          rs_d     = req_rs;
          single_d = 1'b0;
          lo_d     = 1'b0;
          long_d   = needs_long(req_rs, req_data);
          state_d  = S_SETUP;
        end
      end
      default: state_d = S_PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_PWR;
      cnt_q       <= '0;
      step_q      <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      lo_q        <= 1'b0;
      single_q    <= 1'b0;
      long_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      lo_q        <= lo_d;
      single_q    <= single_d;
      long_q      <= long_d;
      init_done_q <= init_done_d;
    end
  end

  logic in_strobe;
  assign in_strobe = (state_q == S_SETUP) || (state_q == S_EN) || (state_q == S_HOLD);

  assign req_ready = (state_q == S_IDLE);
  assign init_done = init_done_q;
  assign lcd_en    = (state_q == S_EN);
  assign lcd_rs    = in_strobe & rs_q;
  assign lcd_data  = in_strobe ? (lo_q ? byte_q[3:0] : byte_q[7:4]) : 4'h0;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer: one instance with default timing, one with
// a 3-cycle enable pulse; vector table plus hand-written multi-cycle sequences.
module tb_lcd_sequencer;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0, rst1 = 1'b0;
  logic       req_valid0 = 1'b0, req_rs0 = 1'b0, req_valid1 = 1'b0, req_rs1 = 1'b0;
  logic [7:0] req_data0 = 8'h00, req_data1 = 8'h00;
  logic       ready0, done0, en0, rs0, ready1, done1, en1, rs1;
  logic [3:0] data0, data1;

  int checks = 0;
  int errors = 0;

  logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};

  typedef struct {
    int         which;
    logic       rs;
    logic [7:0] data;
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
    int         exp_lat;
    int         exp_w;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  lcd_sequencer dut0 (
    .clk(clk), .reset(rst0), .req_valid(req_valid0), .req_rs(req_rs0), .req_data(req_data0),
    .req_ready(ready0), .init_done(done0), .lcd_en(en0), .lcd_rs(rs0), .lcd_data(data0)
  );

  lcd_sequencer #(.EN_HIGH_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(req_valid1), .req_rs(req_rs1), .req_data(req_data1),
    .req_ready(ready1), .init_done(done1), .lcd_en(en1), .lcd_rs(rs1), .lcd_data(data1)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_en(input int w);     return (w == 0) ? en0 : en1; endfunction
  function automatic logic get_rs(input int w);     return (w == 0) ? rs0 : rs1; endfunction
  function automatic logic get_ready(input int w);  return (w == 0) ? ready0 : ready1; endfunction
  function automatic logic get_done(input int w);   return (w == 0) ? done0 : done1; endfunction
  function automatic logic [3:0] get_data(input int w); return (w == 0) ? data0 : data1; endfunction

  task automatic set_req(input int w, input logic v, input logic r, input logic [7:0] d);
    if (w == 0) begin req_valid0 = v; req_rs0 = r; req_data0 = d; end
    else        begin req_valid1 = v; req_rs1 = r; req_data1 = d; end
  endtask

  task automatic set_rst(input int w, input logic v);
    if (w == 0) rst0 = v; else rst1 = v;
  endtask

  task automatic check_idle_bus(input int w, input string tag);
    chk({tag, "_en"},    32'(get_en(w)), 0);
    chk({tag, "_rs"},    32'(get_rs(w)), 0);
    chk({tag, "_data"},  32'(get_data(w)), 0);
    chk({tag, "_ready"}, 32'(get_ready(w)), 0);
    chk({tag, "_done"},  32'(get_done(w)), 0);
  endtask

  task automatic do_reset(input int w);
    set_rst(w, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_idle_bus(w, "reset");
    set_rst(w, 1'b1);
  endtask

  // Starts right after reset is released on a falling edge; stops at the first ready cycle.
  task automatic run_init(input int w, input bit hold_valid, input int exp_w);
    int k = 0, pulses = 0, first_en = -1, hold_k = -1, ready_k = -1, width = 0;
    logic prev_en = 1'b0;
    logic [3:0] got [12];
    bit rs_bad = 0, width_bad = 0, sync_bad = 0, seen_ready = 0;
    for (int i = 0; i < 12; i++) got[i] = 4'hF;
    if (hold_valid) set_req(w, 1'b1, 1'b1, 8'h55);
    while (k < 3000 && !seen_ready) begin
      @(negedge clk);
      k++;
      if (get_ready(w) != get_done(w)) sync_bad = 1;
      if (get_en(w)) begin
        if (!prev_en) begin
          if (pulses < 12) got[pulses] = get_data(w);
          if (first_en < 0) first_en = k;
          pulses++;
          width = 0;
        end
        width++;
        if (get_rs(w)) rs_bad = 1;
      end else if (prev_en) begin
        if (width != exp_w) width_bad = 1;
        hold_k = k;
      end
      prev_en = get_en(w);
      if (get_ready(w)) begin
        seen_ready = 1;
        ready_k = k;
        if (hold_valid) set_req(w, 1'b0, 1'b0, 8'h00);
      end
    end
    $display("init dut%0d: pulses=%0d first_en=%0d ready_at=%0d", w, pulses, first_en, ready_k);
    chk("init_ready_seen", 32'(seen_ready), 1);
    chk("init_pulses", 32'(pulses), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("init_nib%0d", i), 32'(got[i]), 32'(init_nibs[i]));
    chk("init_first_en_not_early", 32'(first_en >= 41), 1);
    chk("init_rs_zero", 32'(rs_bad), 0);
    chk("init_en_width", 32'(width_bad), 0);
    chk("init_ready_done_together", 32'(sync_bad), 0);
    chk("init_last_wait", 32'(ready_k - hold_k), 41);
    chk("init_done_high", 32'(get_done(w)), 1);
  endtask

  task automatic wait_ready(input int w);
    int to = 0;
    @(negedge clk);
    while (!get_ready(w) && to < 300) begin
      @(negedge clk);
      to++;
    end
    chk("ready_wait", 32'(get_ready(w)), 1);
  endtask

  task automatic send_vec(input vec_t v);
    int k = 1, pulses = 0, first_en = -1, width = 0, lat = -1;
    logic [3:0] got [2];
    bit rs_bad = 0, width_bad = 0;
    logic prev_en = 1'b0;
    got[0] = 4'hF; got[1] = 4'hF;
    wait_ready(v.which);
    set_req(v.which, 1'b1, v.rs, v.data);
    @(negedge clk);
    set_req(v.which, 1'b0, ~v.rs, ~v.data);
    chk("ready_drop", 32'(get_ready(v.which)), 0);
    while (lat < 0 && k < 300) begin
      if (get_en(v.which)) begin
        if (!prev_en) begin
          if (pulses < 2) got[pulses] = get_data(v.which);
          if (first_en < 0) first_en = k;
          pulses++;
          width = 0;
        end
        width++;
        if (get_rs(v.which) != v.rs) rs_bad = 1;
      end else if (prev_en && width != v.exp_w) begin
        width_bad = 1;
      end
      prev_en = get_en(v.which);
      if (get_ready(v.which)) lat = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
    $display("byte dut%0d: rs=%0b data=%02h nibbles=%h,%h latency=%0d",
             v.which, v.rs, v.data, got[0], got[1], lat);
    chk("byte_latency", 32'(lat), 32'(v.exp_lat));
    chk("byte_pulses", 32'(pulses), 2);
    chk("byte_hi_nib", 32'(got[0]), 32'(v.exp_hi));
    chk("byte_lo_nib", 32'(got[1]), 32'(v.exp_lo));
    chk("byte_first_en", 32'(first_en), 2);
    chk("byte_rs_steady", 32'(rs_bad), 0);
    chk("byte_en_width", 32'(width_bad), 0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 8'h41, 4'h4, 4'h1, 9,  1};
    vecs[1] = '{0, 1'b0, 8'h01, 4'h0, 4'h1, 47, 1};
    vecs[2] = '{0, 1'b0, 8'h02, 4'h0, 4'h2, 47, 1};
    vecs[3] = '{0, 1'b1, 8'h01, 4'h0, 4'h1, 9,  1};
    vecs[4] = '{0, 1'b0, 8'h28, 4'h2, 4'h8, 9,  1};
    vecs[5] = '{0, 1'b1, 8'hFF, 4'hF, 4'hF, 9,  1};
    vecs[6] = '{0, 1'b0, 8'h03, 4'h0, 4'h3, 9,  1};
    vecs[7] = '{1, 1'b1, 8'h41, 4'h4, 4'h1, 13, 3};
    vecs[8] = '{1, 1'b0, 8'h01, 4'h0, 4'h1, 51, 3};
    vecs[9] = '{1, 1'b1, 8'hA5, 4'hA, 4'h5, 13, 3};

    // Default instance: init with valid held high throughout, which must not be queued.
    do_reset(0);
    run_init(0, 1'b1, 1);
    begin
      bit quiet = 1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (en0 || !ready0) quiet = 0;
      end
      chk("no_queued_accept", 32'(quiet), 1);
    end

    for (int i = 0; i < 10; i++) if (vecs[i].which == 0) send_vec(vecs[i]);

    // Back-to-back: valid held, two bytes, accepts exactly 9 cycles apart.
    begin
      int k = 0, acc = 0, pulses = 0;
      int acc_k [2];
      logic [3:0] got [4];
      logic prev = 1'b0;
      bit done = 0;
      acc_k[0] = -100; acc_k[1] = -100;
      for (int i = 0; i < 4; i++) got[i] = 4'hF;
      wait_ready(0);
      set_req(0, 1'b1, 1'b1, 8'h48);
      while (!done && k < 100) begin
        if (en0 && !prev) begin
          if (pulses < 4) got[pulses] = data0;
          pulses++;
        end
        prev = en0;
        if (acc == 1 && k == acc_k[0] + 1) req_data0 = 8'h49;
        if (acc == 2 && k == acc_k[1] + 1) set_req(0, 1'b0, 1'b0, 8'h00);
        if (acc == 2 && k > acc_k[1] && ready0) done = 1;
        else if (ready0 && req_valid0 && acc < 2) begin
          acc_k[acc] = k;
          acc++;
        end
        @(negedge clk);
        k++;
      end
      $display("b2b dut0: accepts at %0d,%0d nibbles=%h%h,%h%h", acc_k[0], acc_k[1],
               got[0], got[1], got[2], got[3]);
      chk("b2b_done", 32'(done), 1);
      chk("b2b_spacing", 32'(acc_k[1] - acc_k[0]), 9);
      chk("b2b_pulses", 32'(pulses), 4);
      chk("b2b_nib0", 32'(got[0]), 4);
      chk("b2b_nib1", 32'(got[1]), 8);
      chk("b2b_nib2", 32'(got[2]), 4);
      chk("b2b_nib3", 32'(got[3]), 9);
    end

    // Reset during the low-nibble enable pulse, then a full init replay.
    wait_ready(0);
    set_req(0, 1'b1, 1'b1, 8'h41);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 8'h00);
    for (int i = 1; i < 5; i++) @(negedge clk);
    chk("midbyte_en_high", 32'(en0), 1);
    chk("midbyte_lo_nib", 32'(data0), 1);
    rst0 = 1'b0;
    @(negedge clk);
    $display("reset mid-byte dut0: en=%0b rs=%0b data=%h done=%0b", en0, rs0, data0, done0);
    check_idle_bus(0, "midreset");
    rst0 = 1'b1;
    run_init(0, 1'b0, 1);

    // Wide-enable instance.
    do_reset(1);
    run_init(1, 1'b0, 3);
    for (int i = 0; i < 10; i++) if (vecs[i].which == 1) send_vec(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
